// File: rtl/stop_watch_pkg.sv
// rtl/stop_watch_pkg.sv - shared types and helpers for lap_stop_watch
package stop_watch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    // Prescaler width; a divider of 2 still needs one bit
    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // A non-BCD nibble saturates to 9
    function automatic bcd_t clamp_nib(input bcd_t n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down BCD digit with carry/borrow out
module bcd_digit
    import stop_watch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic up,
    input  logic load,
    input  logic clr,
    input  bcd_t load_val,
    output bcd_t value,
    output logic carry
);

    localparam bcd_t MAX_V = bcd_t'(MAX);

    // Carry when stepping up past MAX, borrow when stepping down past 0
    assign carry = en && (up ? (value == MAX_V) : (value == 4'd0));

    // Digit register: clear beats load beats count
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            value <= 4'd0;
        end else if (load) begin
            value <= load_val;
        end else if (en) begin
            if (up) value <= (value == MAX_V) ? 4'd0 : value + 4'd1;
            else    value <= (value == 4'd0) ? MAX_V : value - 4'd1;
        end
    end

endmodule

// File: rtl/lap_stop_watch.sv
// rtl/lap_stop_watch.sv - MM:SS.hh up/down stop watch, optional lap capture (LAP_EN)
module lap_stop_watch
    import stop_watch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start_pause,
    input  logic        i_stop,
    input  logic        i_mode,
    input  logic        i_load,
    input  logic [7:0]  i_preset_m,
    input  logic [7:0]  i_preset_s,
`ifdef LAP_EN
    input  logic        i_lap,
    output logic [23:0] o_lap,
    output logic [3:0]  o_lap_cnt,
`endif
    output logic [3:0]  t_ms0,
    output logic [3:0]  t_ms1,
    output logic [3:0]  t_s0,
    output logic [3:0]  t_s1,
    output logic [3:0]  t_m0,
    output logic [3:0]  t_m1,
    output logic [1:0]  o_state,
    output logic        o_ovf,
    output logic        o_done
);

    localparam int             DIV      = CLK_HZ / 100;
    localparam int             PW       = div_width(DIV);
    localparam logic [PW-1:0]  DIV_LAST = PW'(DIV - 1);
    localparam bcd_t           MAX_M1   = bcd_t'(MAX_MIN / 10);
    localparam bcd_t           MAX_M0   = bcd_t'(MAX_MIN % 10);
    localparam logic [6:0]     MAX_BIN  = 7'(MAX_MIN);
    localparam logic [23:0]    MAX_TIME = {MAX_M1, MAX_M0, 4'd5, 4'd9, 4'd9, 4'd9};

    sw_state_e      state_q, state_d;
    logic           mode_q;
    logic [PW-1:0]  presc_q;
    logic           tick, clr_all, presc_clr, do_load, set_done, hit_zero;
    logic           wrap_up, dig_clr;
    bcd_t           dig    [6];
    bcd_t           ld_val [6];
    logic [6:0]     en_c;
    logic [23:0]    cur_time;
    bcd_t           s_t, s_u, m_t, m_u;
    logic [6:0]     m_bin;
`ifdef LAP_EN
    logic           do_lap;
`endif

    assign cur_time = {dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
    assign tick     = (state_q == RUN) && (presc_q == DIV_LAST);
    assign wrap_up  = tick && !mode_q && (cur_time == MAX_TIME);
    assign hit_zero = tick && mode_q && (cur_time == 24'h000001);
    assign dig_clr  = clr_all || wrap_up;

    // Next state and control strobes; i_stop > i_start_pause > i_lap > i_load
    always_comb begin
        state_d   = state_q;
        clr_all   = 1'b0;
        presc_clr = 1'b0;
        do_load   = 1'b0;
        set_done  = 1'b0;
`ifdef LAP_EN
        do_lap    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_stop) begin
                    clr_all = 1'b1;
                end else if (i_start_pause) begin
                    presc_clr = 1'b1;
                    if (i_mode && (cur_time == 24'h0)) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (i_load) begin
                    do_load = 1'b1;
                end
            end
            RUN, PAUSE: begin
                if (i_stop) begin
                    state_d = IDLE;
                    clr_all = 1'b1;
                end else begin
                    if (i_start_pause) state_d = (state_q == RUN) ? PAUSE : RUN;
`ifdef LAP_EN
                    else if (i_lap) do_lap = 1'b1;
`endif
                    if (hit_zero) begin
                        state_d  = DONE;
                        set_done = 1'b1;
                    end
                end
            end
            default: begin
                if (i_stop) begin
                    state_d = IDLE;
                    clr_all = 1'b1;
                end
            end
        endcase
    end

    // Preset clamping: nibbles to 9 first, then seconds to 59 and minutes to MAX_MIN
    always_comb begin
        s_t = clamp_nib(i_preset_s[7:4]);
        s_u = clamp_nib(i_preset_s[3:0]);
        if (s_t > 4'd5) begin
            s_t = 4'd5;
            s_u = 4'd9;
        end
        m_t   = clamp_nib(i_preset_m[7:4]);
        m_u   = clamp_nib(i_preset_m[3:0]);
        m_bin = 7'(m_t) * 7'd10 + 7'(m_u);
        if (m_bin > MAX_BIN) begin
            m_t = MAX_M1;
            m_u = MAX_M0;
        end
        ld_val[0] = 4'd0;
        ld_val[1] = 4'd0;
        ld_val[2] = s_u;
        ld_val[3] = s_t;
        ld_val[4] = m_u;
        ld_val[5] = m_t;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Direction is only picked up while idle
    always_ff @(posedge clk) begin
        if (!rst_n)               mode_q <= 1'b0;
        else if (state_q == IDLE) mode_q <= i_mode;
    end

    // 10 ms prescaler; holds its partial count across a pause
    always_ff @(posedge clk) begin
        if (!rst_n || clr_all || presc_clr) presc_q <= '0;
        else if (state_q == RUN)            presc_q <= tick ? '0 : presc_q + 1'b1;
    end

    assign en_c[0] = tick;

    for (genvar i = 0; i < 6; i++) begin : g_digit
        bcd_digit #(.MAX((i == 3) ? 5 : 9)) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en_c[i]),
            .up       (!mode_q),
            .load     (do_load),
            .clr      (dig_clr),
            .load_val (ld_val[i]),
            .value    (dig[i]),
            .carry    (en_c[i+1])
        );
    end

    // Sticky status flags; a carry out of the top digit is also a wrap
    always_ff @(posedge clk) begin
        if (!rst_n || clr_all) begin
            o_ovf  <= 1'b0;
            o_done <= 1'b0;
        end else begin
            if (wrap_up || (en_c[6] && !mode_q)) o_ovf <= 1'b1;
            if (set_done)                        o_done <= 1'b1;
        end
    end

`ifdef LAP_EN
    // Lap capture of the pre-edge digits, count saturating at 15
    always_ff @(posedge clk) begin
        if (!rst_n || clr_all) begin
            o_lap     <= 24'h0;
            o_lap_cnt <= 4'd0;
        end else if (do_lap) begin
            o_lap <= cur_time;
            if (o_lap_cnt != 4'd15) o_lap_cnt <= o_lap_cnt + 4'd1;
        end
    end
`endif

    assign t_ms0   = dig[0];
    assign t_ms1   = dig[1];
    assign t_s0    = dig[2];
    assign t_s1    = dig[3];
    assign t_m0    = dig[4];
    assign t_m1    = dig[5];
    assign o_state = state_q;

endmodule

// File: tb/tb_lap_stop_watch.sv
// tb/tb_lap_stop_watch.sv - directed vector bench for lap_stop_watch (LAP_EN aware)
module tb_lap_stop_watch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sp = 1'b0, st = 1'b0, md = 1'b0, ld = 1'b0;
    logic [7:0] pm = 8'h0, ps = 8'h0;
    logic [3:0] a_ms0, a_ms1, a_s0, a_s1, a_m0, a_m1;
    logic [3:0] b_ms0, b_ms1, b_s0, b_s1, b_m0, b_m1;
    logic [1:0] a_state, b_state;
    logic       a_ovf, a_done, b_ovf, b_done;
`ifdef LAP_EN
    logic        lp = 1'b0;
    logic [23:0] a_lap, b_lap;
    logic [3:0]  a_lap_cnt, b_lap_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    lap_stop_watch #(.CLK_HZ(1000), .MAX_MIN(59)) dut (
        .clk(clk), .rst_n(rst_n), .i_start_pause(sp), .i_stop(st), .i_mode(md),
        .i_load(ld), .i_preset_m(pm), .i_preset_s(ps),
`ifdef LAP_EN
        .i_lap(lp), .o_lap(a_lap), .o_lap_cnt(a_lap_cnt),
`endif
        .t_ms0(a_ms0), .t_ms1(a_ms1), .t_s0(a_s0), .t_s1(a_s1), .t_m0(a_m0), .t_m1(a_m1),
        .o_state(a_state), .o_ovf(a_ovf), .o_done(a_done)
    );

    lap_stop_watch #(.CLK_HZ(1000), .MAX_MIN(1)) dut_short (
        .clk(clk), .rst_n(rst_n), .i_start_pause(sp), .i_stop(st), .i_mode(md),
        .i_load(ld), .i_preset_m(pm), .i_preset_s(ps),
`ifdef LAP_EN
        .i_lap(lp), .o_lap(b_lap), .o_lap_cnt(b_lap_cnt),
`endif
        .t_ms0(b_ms0), .t_ms1(b_ms1), .t_s0(b_s0), .t_s1(b_s1), .t_m0(b_m0), .t_m1(b_m1),
        .o_state(b_state), .o_ovf(b_ovf), .o_done(b_done)
    );

    typedef struct {
        string       name;
        logic        sp, st, md, ld;
        logic [7:0]  pm, ps;
        int          wait_n;
        logic [23:0] t;
        logic [1:0]  s;
        logic        ovf, done;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string n, input logic a_sp, a_st, a_md, a_ld,
                                input logic [7:0] a_pm, a_ps, input int w,
                                input logic [23:0] t, input logic [1:0] s,
                                input logic ovf, done);
        vec_t v;
        v.name = n; v.sp = a_sp; v.st = a_st; v.md = a_md; v.ld = a_ld;
        v.pm = a_pm; v.ps = a_ps; v.wait_n = w; v.t = t; v.s = s; v.ovf = ovf; v.done = done;
        return v;
    endfunction

    function automatic logic [31:0] pack_a();
        return {4'h0, a_m1, a_m0, a_s1, a_s0, a_ms1, a_ms0, a_state, a_ovf, a_done};
    endfunction

    function automatic logic [31:0] pack_b();
        return {4'h0, b_m1, b_m0, b_s1, b_s0, b_ms1, b_ms0, b_state, b_ovf, b_done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge: drive for one sampling edge, then release the pulses
    task automatic drive(input logic a_sp, a_st, a_md, a_ld, input logic [7:0] a_pm, a_ps);
        sp = a_sp; st = a_st; md = a_md; ld = a_ld; pm = a_pm; ps = a_ps;
        @(negedge clk);
        sp = 1'b0; st = 1'b0; ld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         name                  sp st md ld pm     ps     wait  time        st   ovf done
        vq.push_back(mk("reset_state",   0, 0, 0, 0, 8'h00, 8'h00, 0,   24'h000000, 2'd0, 0, 0));
        vq.push_back(mk("run_099",       1, 0, 0, 0, 8'h00, 8'h00, 999, 24'h000099, 2'd1, 0, 0));
        vq.push_back(mk("pause_100",     1, 0, 0, 0, 8'h00, 8'h00, 49,  24'h000100, 2'd2, 0, 0));
        vq.push_back(mk("resume_a",      1, 0, 0, 0, 8'h00, 8'h00, 4,   24'h000100, 2'd1, 0, 0));
        vq.push_back(mk("pause_a",       1, 0, 0, 0, 8'h00, 8'h00, 0,   24'h000100, 2'd2, 0, 0));
        vq.push_back(mk("resume_b",      1, 0, 0, 0, 8'h00, 8'h00, 4,   24'h000100, 2'd1, 0, 0));
        vq.push_back(mk("pause_101",     1, 0, 0, 0, 8'h00, 8'h00, 0,   24'h000101, 2'd2, 0, 0));
        vq.push_back(mk("stop_clear",    0, 1, 0, 0, 8'h00, 8'h00, 0,   24'h000000, 2'd0, 0, 0));
        vq.push_back(mk("load_clamp",    0, 0, 0, 1, 8'h7A, 8'h75, 0,   24'h595900, 2'd0, 0, 0));
        vq.push_back(mk("load_nonbcd",   0, 0, 0, 1, 8'h0F, 8'h4C, 0,   24'h094900, 2'd0, 0, 0));
        vq.push_back(mk("stop_preset",   0, 1, 0, 0, 8'h00, 8'h00, 0,   24'h000000, 2'd0, 0, 0));
        vq.push_back(mk("load_down",     0, 0, 1, 1, 8'h00, 8'h01, 0,   24'h000100, 2'd0, 0, 0));
        vq.push_back(mk("down_run",      1, 0, 1, 0, 8'h00, 8'h00, 98,  24'h000091, 2'd1, 0, 0));
        vq.push_back(mk("down_done",     0, 0, 1, 0, 8'h00, 8'h00, 909, 24'h000000, 2'd3, 0, 1));
        vq.push_back(mk("done_ign_sp",   1, 0, 1, 0, 8'h00, 8'h00, 2,   24'h000000, 2'd3, 0, 1));
        vq.push_back(mk("done_stop",     0, 1, 1, 0, 8'h00, 8'h00, 0,   24'h000000, 2'd0, 0, 0));
        vq.push_back(mk("down_zero",     1, 0, 1, 0, 8'h00, 8'h00, 0,   24'h000000, 2'd3, 0, 1));
        vq.push_back(mk("stop_zero",     0, 1, 0, 0, 8'h00, 8'h00, 0,   24'h000000, 2'd0, 0, 0));
        vq.push_back(mk("load_1234",     0, 0, 0, 1, 8'h12, 8'h34, 0,   24'h123400, 2'd0, 0, 0));
        vq.push_back(mk("up_start",      1, 0, 0, 0, 8'h00, 8'h00, 4,   24'h123400, 2'd1, 0, 0));
        vq.push_back(mk("load_in_run",   0, 0, 0, 1, 8'h00, 8'h00, 0,   24'h123400, 2'd1, 0, 0));
        vq.push_back(mk("mode_in_run",   0, 0, 1, 0, 8'h00, 8'h00, 4,   24'h123401, 2'd1, 0, 0));
        vq.push_back(mk("stop_and_sp",   1, 1, 0, 0, 8'h00, 8'h00, 0,   24'h000000, 2'd0, 0, 0));

        idle(2);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].sp, vq[i].st, vq[i].md, vq[i].ld, vq[i].pm, vq[i].ps);
            idle(vq[i].wait_n);
            check(vq[i].name, pack_a(), {4'h0, vq[i].t, vq[i].s, vq[i].ovf, vq[i].done});
        end

        // Overflow on the MAX_MIN=1 instance; the 59-minute one just counts on
        drive(0, 0, 0, 1, 8'h01, 8'h59);
        check("short_load", pack_b(), {4'h0, 24'h015900, 2'd0, 1'b0, 1'b0});
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        idle(1000);
        check("short_wrap", pack_b(), {4'h0, 24'h000000, 2'd1, 1'b1, 1'b0});
        check("long_nowrap", pack_a(), {4'h0, 24'h020000, 2'd1, 1'b0, 1'b0});
        idle(10);
        check("short_cont", pack_b(), {4'h0, 24'h000001, 2'd1, 1'b1, 1'b0});
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        check("short_stop", pack_b(), {4'h0, 24'h000000, 2'd0, 1'b0, 1'b0});

        // Reset mid-run with a start pulse in the same cycle
        drive(0, 0, 0, 1, 8'h01, 8'h59);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        idle(1005);
        check("pre_rst_b", pack_b(), {4'h0, 24'h000000, 2'd1, 1'b1, 1'b0});
        rst_n = 1'b0; sp = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; sp = 1'b0;
        check("rst_a", pack_a(), 32'h0);
        check("rst_b", pack_b(), 32'h0);
        idle(20);
        check("rst_hold", pack_a(), 32'h0);

`ifdef LAP_EN
        check("rst_lap", {4'h0, a_lap, a_lap_cnt}, 32'h0);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        idle(49);
        lp = 1'b1; @(negedge clk); lp = 1'b0;
        check("lap_on_tick", {a_lap, 4'h0, a_lap_cnt}, {24'h000004, 4'h0, 4'd1});
        check("lap_time", pack_a(), {4'h0, 24'h000005, 2'd1, 1'b0, 1'b0});
        for (int k = 0; k < 16; k++) begin
            lp = 1'b1; @(negedge clk); lp = 1'b0;
        end
        check("lap_sat", {28'h0, a_lap_cnt}, 32'd15);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        lp = 1'b1; @(negedge clk); lp = 1'b0;
        check("lap_pause", {4'h0, a_lap, a_state, 2'b0}, {4'h0, 24'h000006, 2'd2, 2'b0});
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        lp = 1'b1; @(negedge clk); lp = 1'b0;
        check("lap_idle", {4'h0, a_lap, a_lap_cnt}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lap_stop_watch.md
# lap_stop_watch

Parametrised stop watch and countdown timer. It replaces the fixed 50 MHz, count-up-only stop watch. A prescaler divides the system clock to a 10 ms tick. A Moore FSM drives a six-digit BCD time register (MM:SS.hh) with up/down mode, preset load, overflow/done flags and optional lap capture. It sits between the debounced button front-end and the 7-segment display driver.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; DIV = CLK_HZ/100 must be an integer ≥ 2
- MAX_MIN, 59, highest minute value, range 1..99; defines the wrap/clamp point
- clk  in  1  system clock
- rst_n  in  1  reset; **one clock; reset is synchronous and active-low**
- i_start_pause  in  1  single-cycle pulse: start/resume, or pause
- i_stop  in  1  single-cycle pulse: stop and clear
- i_mode  in  1  0 = count up, 1 = count down; sampled only in IDLE
- i_load  in  1  pulse: load preset; honoured only in IDLE
- i_preset_m  in  8  BCD minutes preset {m1,m0}
- i_preset_s  in  8  BCD seconds preset {s1,s0}
- i_lap  in  1  pulse: capture lap (LAP_EN only)
- t_ms0, t_ms1, t_s0, t_s1, t_m0, t_m1  out  4 each  live BCD time digits
- o_state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- o_ovf  out  1  sticky: count-up wrapped past MAX_MIN:59.99
- o_done  out  1  countdown reached 00:00.00
- o_lap  out  24  BCD lap time {m1,m0,s1,s0,ms1,ms0} (LAP_EN only)
- o_lap_cnt  out  4  laps captured, saturates at 15 (LAP_EN only)

## Operation
- Reset: state IDLE; all digits 0; prescaler 0; o_ovf=0; o_done=0; o_lap=0; o_lap_cnt=0; mode register 0.
- Input priority in any cycle: i_stop > i_start_pause > i_lap > i_load.
- IDLE: i_start_pause → RUN, prescaler cleared. In down mode with time 00:00.00, i_start_pause → DONE instead. i_load loads the presets and hundredths = 0. Seconds >59 clamp to 59; minutes >MAX_MIN clamp to MAX_MIN; a non-BCD nibble >9 clamps to 9 before the range check.
- RUN: i_start_pause → PAUSE; i_stop → IDLE.
- PAUSE: i_start_pause → RUN with the prescaler value retained, so the partial tick is kept; i_stop → IDLE.
- DONE: i_stop → IDLE; i_start_pause is ignored.
- Entering IDLE via i_stop clears the digits, prescaler, o_ovf, o_done, o_lap and o_lap_cnt. The preset is not retained.
- Tick: prescaler counts 0..DIV-1 only in RUN. Time advances on the edge where the prescaler wraps DIV-1→0.
- Up: ripple carry ms0→ms1→s0→s1→m0→m1 at 9/9/9/5/9 boundaries. At MAX_MIN:59.99 the next tick gives 00:00.00 and sets o_ovf; counting continues.
- Down: borrow chain mirrors the up carry. The tick that produces 00:00.00 moves the FSM to DONE and sets o_done. Time then holds at zero.
- Lap: i_lap in RUN or PAUSE copies the current digits into o_lap and increments o_lap_cnt. It is ignored in IDLE and DONE.

## Timing
- All outputs are registered; no combinational input→output paths.
- A pulse sampled at edge E changes o_state at E.
- First tick after a start from IDLE: time changes at edge E+DIV.
- o_done and the DONE state appear on the same edge as 00:00.00.
- o_lap reflects the digits present before the capture edge. If a tick and i_lap coincide, the lap gets the pre-tick value.
- Synchronous reset mid-count: everything returns to reset values at the next edge; a pending pulse in that cycle is discarded.

## Configuration
- LAP_EN defined: i_lap, o_lap and o_lap_cnt exist and behave as above.
- LAP_EN undefined: these ports and registers are removed; all other behaviour is identical.

## Structure
- Package stop_watch_pkg holds the state enum (IDLE/RUN/PAUSE/DONE), a BCD digit typedef, and the DIV width function $clog2(DIV).
- Sub-module bcd_digit: one BCD digit with parameter MAX, inputs en/up/load/clr, outputs value and carry/borrow. It is instantiated six times in a chain.

## Test plan
- CLK_HZ=1000 (DIV=10): start, run 1000 clocks → 00:01.00; pause 50 clocks → unchanged; resume 5 clocks, pause, resume 5 clocks → 00:01.01.
- MAX_MIN=1, up mode, preset 01:59, start, 100 ticks → 00:00.00 and o_ovf=1; i_stop → o_ovf=0, digits 0.
- Down mode, preset 00:01, start, 100 ticks → 00:00.00, o_state=3, o_done=1; i_start_pause ignored; i_stop → IDLE.
- Preset i_preset_s=8'h75, i_preset_m=8'h7A with MAX_MIN=59 → loads 59:59.00.
- LAP_EN: i_lap coincident with the tick 00:00.04→.05 → o_lap=00:00.04, o_lap_cnt=1; 16 further laps → o_lap_cnt=15.
- i_stop and i_start_pause asserted together in RUN → IDLE, digits cleared; rst_n low for one edge mid-RUN → all outputs at reset values.
